// File: rtl/alu_dispatch.sv
// Requester side of the ALU start/done handshake: tagged op FIFO, issue FSM, valid/ready result port.
// Define ALU_DISPATCH_TIMEOUT_EN to bound the START and RELEASE waits to TIMEOUT cycles.
module alu_dispatch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             in_fun7,
    input  logic [2:0]             in_fun3,
    input  logic [31:0]            in_rs1,
    input  logic [31:0]            in_rs2,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   alu_start,
    output logic [6:0]             alu_fun7,
    output logic [2:0]             alu_fun3,
    output logic [31:0]            alu_rs1,
    output logic [31:0]            alu_rs2,
    input  logic [31:0]            alu_res,
    input  logic                   alu_zero,
    input  logic                   alu_neg,
    input  logic                   alu_busy,
    input  logic                   alu_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_res,
    output logic                   out_zero,
    output logic                   out_neg,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("alu_dispatch: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef struct packed {
        logic [6:0]       fun7;
        logic [2:0]       fun3;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef enum logic [1:0] {StIdle, StSetup, StStart, StRelease} state_e;

    op_t              mem_q [DEPTH];
    op_t              head;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    state_e           state_q;
    logic [TAG_W-1:0] op_tag_q;
    logic             push;
    logic             pop;

    // Full means not ready, even if a pop frees a slot on the same edge.
    assign in_ready   = count_q < CNT_W'(DEPTH);
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == StIdle) && (count_q != '0) && (!out_valid || out_ready);
    assign head       = mem_q[rptr_q];
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= op_t'{fun7: in_fun7, fun3: in_fun3, rs1: in_rs1, rs2: in_rs2,
                                   tag: in_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

`ifdef ALU_DISPATCH_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_tag_q  <= '0;
            alu_start <= 1'b0;
            alu_fun7  <= '0;
            alu_fun3  <= '0;
            alu_rs1   <= '0;
            alu_rs2   <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
            out_tag   <= '0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            // A capture later in this block overrides the consumer's clear.
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (pop) begin
                        alu_fun7 <= head.fun7;
                        alu_fun3 <= head.fun3;
                        alu_rs1  <= head.rs1;
                        alu_rs2  <= head.rs2;
                        op_tag_q <= head.tag;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    if (!alu_busy) begin
                        alu_start <= 1'b1;
                        state_q   <= StStart;
`ifdef ALU_DISPATCH_TIMEOUT_EN
                        to_cnt_q  <= '0;
`endif
                    end
                end
                StStart: begin
                    if (alu_done) begin
                        out_res   <= alu_res;
                        out_zero  <= alu_zero;
                        out_neg   <= alu_neg;
                        out_tag   <= op_tag_q;
                        out_valid <= 1'b1;
                        alu_start <= 1'b0;
                        state_q   <= StRelease;
`ifdef ALU_DISPATCH_TIMEOUT_EN
                        err_q     <= 1'b0;
                        to_cnt_q  <= '0;
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        out_res   <= '0;
                        out_zero  <= 1'b0;
                        out_neg   <= 1'b0;
                        out_tag   <= op_tag_q;
                        err_q     <= 1'b1;
                        out_valid <= 1'b1;
                        alu_start <= 1'b0;
                        state_q   <= StRelease;
                        to_cnt_q  <= '0;
                    end else begin
                        to_cnt_q  <= to_cnt_q + TO_W'(1);
`endif
                    end
                end
                StRelease: begin
                    if (!alu_done) begin
                        state_q <= StIdle;
`ifdef ALU_DISPATCH_TIMEOUT_EN
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: ALU stub, queue-based reference model, directed + random ops.
// Compile with ALU_DISPATCH_TIMEOUT_EN to also exercise the timeout path with TIMEOUT=8.
module tb_alu_dispatch;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
`ifdef ALU_DISPATCH_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 8;
`else
    localparam int unsigned TIMEOUT = 64;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid, in_ready;
    logic [6:0]       in_fun7;
    logic [2:0]       in_fun3;
    logic [31:0]      in_rs1, in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             alu_start;
    logic [6:0]       alu_fun7;
    logic [2:0]       alu_fun3;
    logic [31:0]      alu_rs1, alu_rs2, alu_res, alu_val;
    logic             alu_zero, alu_neg, alu_busy, alu_done;
    logic             out_valid, out_ready, out_zero, out_neg, out_err;
    logic [31:0]      out_res;
    logic [TAG_W-1:0] out_tag;
    logic [$clog2(DEPTH):0] fifo_count;

    alu_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_fun7(in_fun7), .in_fun3(in_fun3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .alu_start(alu_start), .alu_fun7(alu_fun7), .alu_fun3(alu_fun3),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_res(alu_res), .alu_zero(alu_zero),
        .alu_neg(alu_neg), .alu_busy(alu_busy), .alu_done(alu_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_zero(out_zero),
        .out_neg(out_neg), .out_tag(out_tag), .out_err(out_err), .fifo_count(fifo_count)
    );

    function automatic logic [31:0] alu_fn(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return f7[5] ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // ALU stub: done follows start after alu_lat cycles, drops with start; never done when hung.
    logic       alu_hang;
    logic [7:0] alu_lat;
    logic [7:0] lat_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                lat_cnt <= '0;
        else if (!alu_start)       lat_cnt <= '0;
        else if (lat_cnt != 8'hff) lat_cnt <= lat_cnt + 8'd1;
    end
    assign alu_done = alu_start && !alu_hang && (lat_cnt >= alu_lat);
    assign alu_val  = alu_fn(alu_fun7, alu_fun3, alu_rs1, alu_rs2);
    assign alu_res  = alu_done ? alu_val : 32'hDEAD_BEEF;
    assign alu_zero = alu_done ? (alu_val == 32'd0) : 1'b1;
    assign alu_neg  = alu_done ? alu_val[31] : 1'b1;

    typedef struct {
        logic [31:0]      res;
        logic             zero;
        logic             neg;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   results = 0;
    bit   pushed;
    bit   rnd_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe both handshakes at the negedge, return just after the posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        pushed = 1'b0;
        if (in_valid && in_ready) begin
            pushed = 1'b1;
            e.res = alu_fn(in_fun7, in_fun3, in_rs1, in_rs2);
            e.err = 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            if (alu_hang) begin
                e.res = '0;
                e.err = 1'b1;
            end
`endif
            e.zero = (e.res == 32'd0) && !e.err;
            e.neg  = e.res[31];
            e.tag  = in_tag;
            exp_q.push_back(e);
        end
        if (out_valid && out_ready) begin
            results++;
            if (exp_q.size() == 0) begin
                check("spurious_result", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("out_res", out_res, e.res);
                check("out_zero", 32'(out_zero), 32'(e.zero));
                check("out_neg", 32'(out_neg), 32'(e.neg));
                check("out_tag", 32'(out_tag), 32'(e.tag));
                check("out_err", 32'(out_err), 32'(e.err));
            end
        end
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            alu_busy  = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic send(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t);
        bit acc;
        acc = 1'b0;
        in_fun7 = f7; in_fun3 = f3; in_rs1 = a; in_rs2 = b; in_tag = t;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !acc; n++) begin
            step();
            acc = pushed;
        end
        in_valid = 1'b0;
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain(input int max_cycles);
        for (int n = 0; n < max_cycles && exp_q.size() != 0; n++) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        step();
        step();
    endtask

    task automatic wait_start();
        for (int n = 0; n < 50 && !alu_start; n++) step();
        check("start_seen", 32'(alu_start), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        int r0;
        in_valid = 1'b0; in_fun7 = '0; in_fun3 = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
        out_ready = 1'b1; alu_busy = 1'b0; alu_hang = 1'b0; alu_lat = 8'd0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_alu_rs1", alu_rs1, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res", out_res, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ADD: out_valid exactly three edges after the accept edge
        send(7'h00, 3'd0, 32'd5, 32'd7, 4'd3);
        step();
        check("lat_edge1_valid", 32'(out_valid), 32'd0);
        step();
        check("lat_edge2_valid", 32'(out_valid), 32'd0);
        check("lat_edge2_start", 32'(alu_start), 32'd1);
        check("lat_edge2_rs1", alu_rs1, 32'd5);
        step();
        check("lat_edge3_valid", 32'(out_valid), 32'd1);
        check("add_res", out_res, 32'd12);
        check("add_tag", 32'(out_tag), 32'd3);
        drain(20);

        // SUB to negative, SUB to zero, in order
        send(7'h20, 3'd0, 32'd3, 32'd5, 4'd5);
        send(7'h20, 3'd0, 32'd9, 32'd9, 4'd6);
        drain(40);

        // Fill with consumer stalled; extra op must be refused while full
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(7'h00, 3'd0, 32'(100 + i), 32'(i), 4'(8 + i));
        in_fun7 = 7'h00; in_fun3 = 3'd0; in_rs1 = 32'd1; in_rs2 = 32'd1; in_tag = 4'd15;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("full_count", 32'(fifo_count), 32'd4);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("held_valid", 32'(out_valid), 32'd1);
            check("held_tag", 32'(out_tag), 32'd8);
            check("held_res", out_res, 32'd100);
        end
        in_valid = 1'b0;
        r0 = results;
        out_ready = 1'b1;
        drain(100);
        check("full_results", 32'(results - r0), 32'd5);

        // Busy holds off start in SETUP; start follows the cycle after busy falls
        alu_busy = 1'b1;
        send(7'h00, 3'd7, 32'h0000_F0F0, 32'h0000_FF00, 4'd2);
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            check("busy_no_start", 32'(alu_start), 32'd0);
        end
        check("setup_fun3", 32'(alu_fun3), 32'd7);
        alu_busy = 1'b0;
        step();
        check("start_after_busy", 32'(alu_start), 32'd1);
        drain(20);

        // Randomized traffic with variable ALU latency, busy and consumer backpressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            alu_lat = 8'($urandom_range(0, 3));
            send(7'($urandom), 3'($urandom), $urandom, $urandom, 4'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end
        rnd_mode = 1'b0;
        out_ready = 1'b1;
        alu_busy = 1'b0;
        drain(2000);
        alu_lat = 8'd0;

        // Reset while in START with two queued ops
        alu_hang = 1'b1;
        send(7'h00, 3'd0, 32'd1, 32'd1, 4'd1);
        wait_start();
        send(7'h00, 3'd0, 32'd2, 32'd2, 4'd2);
        send(7'h00, 3'd0, 32'd3, 32'd3, 4'd4);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", 32'(alu_start), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        alu_hang = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_valid", 32'(out_valid), 32'd0);
            check("post_rst_start", 32'(alu_start), 32'd0);
        end

`ifdef ALU_DISPATCH_TIMEOUT_EN
        // ALU never completes: error result after TIMEOUT cycles in START
        alu_hang = 1'b1;
        send(7'h00, 3'd0, 32'd1, 32'd2, 4'd9);
        wait_start();
        for (int i = 0; i < 7; i++) begin
            step();
            check("to_wait_valid", 32'(out_valid), 32'd0);
        end
        step();
        check("to_valid", 32'(out_valid), 32'd1);
        check("to_err", 32'(out_err), 32'd1);
        check("to_res", out_res, 32'd0);
        alu_hang = 1'b0;
        send(7'h00, 3'd0, 32'd20, 32'd22, 4'd10);
        drain(40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
